mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the processor's data bus. The processor is the initiator; this block decodes and answers its loads and stores.
- Sits beside the data RAM and decodes a small register window at BASE_ADDR.
- Provides:
  - a latched 32-bit PortOut register;
  - a synchronized PortIn read path;
  - a byte TX FIFO that drains through an 8N1 serial transmitter.
- Reads are combinational, so a single-cycle load completes in the same cycle. Writes commit on the rising clk edge.

---
 rtl/mmio_port_responder_if.sv | 26 ++
 rtl/mmio_port_responder.sv | 194 +++++++++++++++++++
 tb/tb_mmio_port_responder.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_port_responder_if.sv
// rtl/mmio_port_responder_if.sv - processor data-bus bundle seen by the MMIO responder
//
// Purpose : groups the load/store signals the processor drives toward the
//           register window, plus the combinational answer (ReadData/Hit).
// Signals : Address[31:0], WriteData[31:0], MemWrite, MemRead  (initiator -> responder)
//           ReadData[31:0], Hit                                 (responder -> initiator)
// Modports: master = processor side, slave = responder side.

interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - MMIO register window: PortOut, synchronized PortIn, byte TX FIFO + 8N1 transmitter
//
// Purpose : decodes a 32-byte window at BASE_ADDR on the processor data bus.
//           Loads are answered combinationally; stores commit on rising clk.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           bus (slave)       - Address/WriteData/MemWrite/MemRead in, ReadData/Hit out
//           i_PortIn[7:0]     - external asynchronous inputs
//           o_PortOut[31:0]   - PORT_OUT register
//           o_TxSerial        - serial line, idle high
//           o_TxBusy          - high while a frame is on the line
//           o_IrqEdge         - |EDGE_CAP (only with PORTIN_EDGE_EN)
// Options : define PORTIN_EDGE_EN to add the EDGE_CAP register at offset 0x10.

module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_port_responder_if.slave bus,
  input  logic [7:0]           i_PortIn,
  output logic [31:0]          o_PortOut,
  output logic                 o_TxSerial,
  output logic                 o_TxBusy
`ifdef PORTIN_EDGE_EN
  ,
  output logic                 o_IrqEdge
`endif
);

  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNTW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [4:0]      DEPTH_C  = 5'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] CLK_LAST = CNTW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Decode
  logic       w_hit;
  logic [2:0] w_off;
  logic       w_wr;
  logic       w_unused;

  assign w_hit    = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign w_off    = bus.Address[4:2];
  assign w_wr     = bus.MemWrite & w_hit;
  assign w_unused = ^bus.Address[1:0];

  // PORT_OUT
  logic [31:0] r_port_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_port_out <= 32'h0;
    else if (w_wr && w_off == 3'd0) r_port_out <= bus.WriteData;
  end
  assign o_PortOut = r_port_out;

  // PortIn two-flop synchronizer
  logic [7:0] r_pin_meta, r_pin_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pin_meta <= 8'h0;
      r_pin_sync <= 8'h0;
    end else begin
      r_pin_meta <= i_PortIn;
      r_pin_sync <= r_pin_meta;
    end
  end

  // TX FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_overflow;
  logic          w_full, w_empty, w_push_req, w_push, w_pop;
  state_t        r_state, w_next;

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == 5'd0);
  assign w_push_req = w_wr && (w_off == 3'd2);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      // A dropped push in the same cycle as a clear leaves the flag set.
      if (w_push_req && !w_push)
        r_overflow <= 1'b1;
      else if (w_wr && w_off == 3'd3 && bus.WriteData[8])
        r_overflow <= 1'b0;
    end
  end

  // Transmitter
  logic [CNTW-1:0] r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            w_bit_done;

  assign w_bit_done = (r_clk_cnt == CLK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_TxSerial = 1'b1;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_START;
      S_START: begin
        o_TxSerial = 1'b0;
        if (w_bit_done) w_next = S_DATA;
      end
      S_DATA:  begin
        o_TxSerial = r_shift[r_bit_idx];
        if (w_bit_done && r_bit_idx == 3'd7) w_next = S_STOP;
      end
      S_STOP:  if (w_bit_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h0;
    end else if (r_state == S_IDLE) begin
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      if (w_pop) r_shift <= r_mem[r_rd_ptr];
    end else begin
      r_clk_cnt <= w_bit_done ? '0 : r_clk_cnt + CNTW'(1);
      // Index wraps 7 -> 0 on the last data bit, ready for the next frame.
      if (r_state == S_DATA && w_bit_done) r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  assign o_TxBusy = (r_state != S_IDLE);

`ifdef PORTIN_EDGE_EN
  logic [7:0] r_pin_prev, r_edge_cap, w_edge_clr;
  assign w_edge_clr = (w_wr && w_off == 3'd4) ? bus.WriteData[7:0] : 8'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pin_prev <= 8'h0;
      r_edge_cap <= 8'h0;
    end else begin
      r_pin_prev <= r_pin_sync;
      // OR-ing the new rising edges in after the clear makes set win.
      r_edge_cap <= (r_edge_cap & ~w_edge_clr) | (r_pin_sync & ~r_pin_prev);
    end
  end
  assign o_IrqEdge = |r_edge_cap;
`endif

  // Read mux
  logic [31:0] w_rdata;
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      3'd0: w_rdata = r_port_out;
      3'd1: w_rdata = {24'h0, r_pin_sync};
      3'd3: w_rdata = {23'h0, r_overflow, r_count[3:0], 1'b0, o_TxBusy, w_empty, w_full};
`ifdef PORTIN_EDGE_EN
      3'd4: w_rdata = {24'h0, r_edge_cap};
`endif
      default: w_rdata = 32'h0;
    endcase
  end

  assign bus.Hit      = w_hit;
  assign bus.ReadData = (bus.MemRead && w_hit) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_mmio_port_responder.sv
// tb/tb_mmio_port_responder.sv - self-checking bench for mmio_port_responder

module tb_mmio_port_responder;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  port_in;
  logic [31:0] port_out;
  logic        tx_serial, tx_busy;
`ifdef PORTIN_EDGE_EN
  logic        irq_edge;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] m_port_out;
  logic [7:0]  m_pin;
  logic [7:0]  m_txq[$];
  logic [7:0]  rx_q[$];
  logic [39:0] last_ser, last_busy;

  always #5 clk = ~clk;

  mmio_port_responder_if bus();

  mmio_port_responder #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .i_PortIn  (port_in),
    .o_PortOut (port_out),
    .o_TxSerial(tx_serial),
    .o_TxBusy  (tx_busy)
`ifdef PORTIN_EDGE_EN
    ,
    .o_IrqEdge (irq_edge)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    bus.Address   = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic lw(input logic [31:0] addr, output logic [31:0] data, output logic hit);
    bus.Address = addr;
    bus.MemRead = 1'b1;
    #1;
    data = bus.ReadData;
    hit  = bus.Hit;
    bus.MemRead = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (rx_q.size() < n) begin
      checks++;
      errors++;
      $error("FAIL rx_timeout observed=%0d expected=%0d", rx_q.size(), n);
    end
  endtask

  // Serial line receiver: samples once per cycle, reconstructs 8N1 frames.
  initial begin : rx_monitor
    logic [39:0] s, bz;
    logic        abort;
    logic [7:0]  b;
    forever begin
      tick();
      if (!rst && tx_serial === 1'b0) begin
        s = '0; bz = '0; abort = 1'b0;
        s[0]  = tx_serial;
        bz[0] = tx_busy;
        for (int k = 1; k < 40; k++) begin
          tick();
          if (rst) abort = 1'b1;
          s[k]  = tx_serial;
          bz[k] = tx_busy;
        end
        if (!abort) begin
          for (int i = 0; i < 8; i++) b[i] = s[6 + 4 * i];
          last_ser  = s;
          last_busy = bz;
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] rd, wd, addr;
    logic        hit;
    logic [7:0]  v, d;
    logic [39:0] exp_wave;
    int          slot;

    rst = 1'b1;
    port_in = 8'h00;
    m_pin = 8'h00;
    bus.Address = 32'h0; bus.WriteData = 32'h0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_port_out", port_out, 0);
    chk("rst_tx_serial", tx_serial, 1);
    chk("rst_tx_busy", tx_busy, 0);
`ifdef PORTIN_EDGE_EN
    chk("rst_irq_edge", irq_edge, 0);
`endif
    rst = 1'b0;
    tick();
    lw(BASE + 32'hC, rd, hit);
    chk("rst_status", rd, 32'h0000_0002);
    m_port_out = 32'h0;

    // PORT_OUT store/load
    sw(BASE, 32'hDEAD_BEEF);
    m_port_out = 32'hDEAD_BEEF;
    chk("port_out_pin", port_out, m_port_out);
    lw(BASE, rd, hit);
    chk("port_out_read", rd, m_port_out);
    chk("port_out_hit", hit, 1);
    lw(32'h0000_00FC, rd, hit);
    chk("miss_hit", hit, 0);
    chk("miss_rdata", rd, 0);
    bus.Address = BASE; bus.MemRead = 1'b0; #1;
    chk("no_memread_rdata", bus.ReadData, 0);
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      addr = BASE | 32'($urandom_range(0, 3));
      sw(addr, wd);
      m_port_out = wd;
      lw(BASE | 32'($urandom_range(0, 3)), rd, hit);
      chk("port_out_rand", rd, m_port_out);
    end
    sw(BASE + 32'h20, $urandom);
    chk("miss_write_ignored", port_out, m_port_out);

    // PORT_IN synchronizer latency
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 8'hA5 : (m_pin ^ 8'($urandom_range(1, 255)));
      port_in = v;
      lw(BASE + 32'h4, rd, hit);
      chk("pin_edge0_old", rd, {24'h0, m_pin});
      tick();
      lw(BASE + 32'h4, rd, hit);
      chk("pin_edge1_old", rd, {24'h0, m_pin});
      tick();
      m_pin = v;
      lw(BASE + 32'h4, rd, hit);
      chk("pin_edge2_new", rd, {24'h0, m_pin});
    end

    // Write-only / unmapped offsets
    lw(BASE + 32'h8, rd, hit);
    chk("tx_data_reads0", rd, 0);
`ifdef PORTIN_EDGE_EN
    for (int off = 5; off < 8; off++) begin
`else
    for (int off = 4; off < 8; off++) begin
`endif
      sw(BASE + 32'(off * 4), $urandom);
      lw(BASE + 32'(off * 4), rd, hit);
      chk("unmapped_read0", rd, 0);
    end
    chk("unmapped_port_out", port_out, m_port_out);
    lw(BASE + 32'hC, rd, hit);
    chk("unmapped_status", rd, 32'h0000_0002);

    // Single 0x55 frame: exact waveform and busy width
    rx_q.delete();
    sw(BASE + 32'h8, 32'h0000_0055);
    wait_rx(1, 80);
    d = 8'h55;
    for (int k = 0; k < 40; k++) begin
      slot = k / CPB;
      exp_wave[k] = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : d[slot - 1];
    end
    chk("frame55_wave", last_ser, exp_wave);
    chk("frame55_busy", last_busy, {40{1'b1}});
    tick();
    chk("frame55_busy_end", tx_busy, 0);
    chk("frame55_idle_line", tx_serial, 1);

    // Random bytes, back-to-back pushes
    rx_q.delete();
    m_txq.delete();
    for (int i = 0; i < 3; i++) begin
      v = 8'($urandom);
      m_txq.push_back(v);
      sw(BASE + 32'h8, {$urandom, v} >> 0 & 32'hFFFF_FF00 | 32'(v));
    end
    wait_rx(3, 200);
    for (int i = 0; i < 3; i++) begin
      if (rx_q.size() > 0 && m_txq.size() > 0)
        chk("rand_byte", rx_q.pop_front(), m_txq.pop_front());
    end

    // Overflow: six pushes into a depth-4 FIFO
    rx_q.delete();
    m_txq.delete();
    for (int i = 1; i <= 6; i++) begin
      bus.Address = BASE + 32'h8; bus.WriteData = 32'(i); bus.MemWrite = 1'b1;
      tick();
      if (i <= 5) m_txq.push_back(8'(i));
    end
    bus.MemWrite = 1'b0;
    lw(BASE + 32'hC, rd, hit);
    chk("ovf_status_full", rd, 32'h100 | (32'(DEPTH) << 4) | 32'h4 | 32'h1);
    wait_rx(5, 300);
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > 0 && m_txq.size() > 0)
        chk("ovf_byte", rx_q.pop_front(), m_txq.pop_front());
    end
    tick();
    lw(BASE + 32'hC, rd, hit);
    chk("ovf_sticky", rd, 32'h0000_0102);
    sw(BASE + 32'hC, 32'h0000_00FF);
    lw(BASE + 32'hC, rd, hit);
    chk("ovf_clear_needs_bit8", rd, 32'h0000_0102);
    sw(BASE + 32'hC, 32'h0000_0100);
    lw(BASE + 32'hC, rd, hit);
    chk("ovf_cleared", rd, 32'h0000_0002);

    // Reset mid-frame
    port_in = 8'hC3;
    rx_q.delete();
    sw(BASE + 32'h8, 32'h0000_0000);
    sw(BASE + 32'h8, 32'h0000_00F0);
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk("midrst_serial", tx_serial, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_port_out", port_out, 0);
    lw(BASE + 32'h4, rd, hit);
    chk("midrst_pin_sync", rd, 0);
    lw(BASE + 32'hC, rd, hit);
    chk("midrst_status", rd, 32'h0000_0002);
    tick();
    tick();
    rst = 1'b0;
    m_port_out = 32'h0;
    m_pin = 8'h00;
    repeat (60) tick();
    chk("postrst_line_idle", tx_serial, 1);
    chk("postrst_no_frames", rx_q.size(), 0);

`ifdef PORTIN_EDGE_EN
    // Edge capture
    port_in = 8'h00;
    repeat (3) tick();
    sw(BASE + 32'h10, 32'h0000_00FF);
    lw(BASE + 32'h10, rd, hit);
    chk("edge_cleared", rd, 0);
    chk("edge_irq_clear", irq_edge, 0);
    port_in = 8'h08;
    repeat (3) tick();
    port_in = 8'h00;
    repeat (3) tick();
    lw(BASE + 32'h10, rd, hit);
    chk("edge_bit3", rd, 32'h08);
    chk("edge_irq", irq_edge, 1);
    sw(BASE + 32'h10, 32'h0000_0008);
    lw(BASE + 32'h10, rd, hit);
    chk("edge_bit3_clr", rd, 0);
    chk("edge_irq_clr", irq_edge, 0);
    v = 8'($urandom_range(1, 255));
    port_in = v;
    repeat (4) tick();
    lw(BASE + 32'h10, rd, hit);
    chk("edge_rand", rd, {24'h0, v});
    port_in = 8'h00;
    repeat (3) tick();
    sw(BASE + 32'h10, 32'h0000_00FF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
